// File: rtl/muldiv_stall_ctrl.sv
// Issue/stall sequencer for the shared iterative mul/div unit in EXE.
// Counts the unit's fixed latency, latches the result and counts stall cycles.
module muldiv_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_valid_EXE,
  input  logic        md_is_div_EXE,
  input  logic        flush_EXE,
  input  logic        hold_EXE,
  input  logic [31:0] unit_result,
  output logic        unit_start,
  output logic        unit_is_div,
  output logic        unit_abort,
  output logic        stall_req,
  output logic        md_ready_EXE,
  output logic [31:0] result_EXE,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              start_s, start_is_div_s, abort_s, stall_s;

  // Next-state, counter, result capture and unit handshake decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_div_d       = is_div_q;
    result_d       = result_q;
    start_s        = 1'b0;
    start_is_div_s = 1'b0;
    abort_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_valid_EXE && !flush_EXE) begin
          start_s        = 1'b1;
          start_is_div_s = md_is_div_EXE;
          cnt_d          = md_is_div_EXE ? DIV_LOAD : MUL_LOAD;
          is_div_d       = md_is_div_EXE;
          state_d        = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush_EXE) begin
          abort_s = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          result_d = unit_result;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (flush_EXE || !hold_EXE) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stall request and saturating stall counter; gated by rst_n so reset quiets all outputs.
  always_comb begin
    stall_s     = rst_n & md_valid_EXE & ~flush_EXE & (state_q != S_DONE);
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      is_div_q    <= 1'b0;
      result_q    <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      result_q    <= result_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign unit_start   = rst_n & start_s;
  assign unit_is_div  = rst_n & start_is_div_s;
  assign unit_abort   = rst_n & abort_s;
  assign stall_req    = stall_s;
  assign md_ready_EXE = (state_q == S_DONE);
  assign result_EXE   = result_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// Scoreboard bench for muldiv_stall_ctrl: results queued at issue, popped when md_ready_EXE rises.
module tb_muldiv_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_valid_EXE, md_is_div_EXE, flush_EXE, hold_EXE;
  logic [31:0] unit_result;
  logic        unit_start, unit_is_div, unit_abort, stall_req, md_ready_EXE;
  logic [31:0] result_EXE, stall_cycles;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] last_result = 32'd0;

  muldiv_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .md_valid_EXE(md_valid_EXE), .md_is_div_EXE(md_is_div_EXE),
    .flush_EXE(flush_EXE), .hold_EXE(hold_EXE), .unit_result(unit_result),
    .unit_start(unit_start), .unit_is_div(unit_is_div), .unit_abort(unit_abort),
    .stall_req(stall_req), .md_ready_EXE(md_ready_EXE),
    .result_EXE(result_EXE), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Full op: issue, LAT busy cycles, then hold_n held DONE cycles plus one releasing DONE cycle.
  task automatic run_op(input logic div, input logic [31:0] val, input int hold_n);
    int lat;
    lat = div ? DIV_LAT : MUL_LAT;
    next_cycle();
    md_valid_EXE = 1'b1; md_is_div_EXE = div; flush_EXE = 1'b0; hold_EXE = 1'b0;
    unit_result = 32'h0;
    sample();
    checks++;
    if (unit_start !== 1'b1 || unit_is_div !== div || stall_req !== 1'b1 || unit_abort !== 1'b0) begin
      errors++;
      $display("FAIL issue: start=%b is_div=%b stall=%b abort=%b, expected 1 %b 1 0",
               unit_start, unit_is_div, stall_req, unit_abort, div);
    end
    exp_q.push_back(val);
    exp_stall = exp_stall + 32'(lat + 1);
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      unit_result = (k == lat) ? val : (32'hA5A5_0000 | 32'(k));
      sample();
      checks++;
      if (unit_start !== 1'b0 || unit_is_div !== 1'b0 || stall_req !== 1'b1 ||
          md_ready_EXE !== 1'b0 || unit_abort !== 1'b0) begin
        errors++;
        $display("FAIL busy k=%0d: start=%b is_div=%b stall=%b ready=%b abort=%b, expected 0 0 1 0 0",
                 k, unit_start, unit_is_div, stall_req, md_ready_EXE, unit_abort);
      end
    end
    for (int h = 0; h <= hold_n; h++) begin
      next_cycle();
      hold_EXE = (h < hold_n);
      unit_result = 32'h5A5A_5A5A;
      sample();
      checks++;
      if (md_ready_EXE !== 1'b1 || stall_req !== 1'b0 || unit_start !== 1'b0) begin
        errors++;
        $display("FAIL done h=%0d: ready=%b stall=%b start=%b, expected 1 0 0",
                 h, md_ready_EXE, stall_req, unit_start);
      end
      if (h == 0 && md_ready_EXE === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: result produced with empty queue, got %h", result_EXE);
        end else begin
          last_result = exp_q.pop_front();
        end
      end
      checks++;
      if (result_EXE !== last_result) begin
        errors++;
        $display("FAIL result h=%0d: got %h expected %h", h, result_EXE, last_result);
      end
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, exp_stall);
    end
    hold_EXE = 1'b0;
  endtask

  task automatic idle_cycle();
    next_cycle();
    md_valid_EXE = 1'b0; flush_EXE = 1'b0; hold_EXE = 1'b0;
    sample();
    checks++;
    if (md_ready_EXE !== 1'b0 || stall_req !== 1'b0 || unit_start !== 1'b0 || unit_abort !== 1'b0) begin
      errors++;
      $display("FAIL idle: ready=%b stall=%b start=%b abort=%b, expected 0 0 0 0",
               md_ready_EXE, stall_req, unit_start, unit_abort);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    md_valid_EXE = 1'b1; md_is_div_EXE = 1'b0; flush_EXE = 1'b0; hold_EXE = 1'b0;
    unit_result = 32'h0;
    repeat (3) @(posedge clk);
    sample();
    checks++;
    if (unit_start !== 1'b0 || unit_abort !== 1'b0 || stall_req !== 1'b0 || md_ready_EXE !== 1'b0 ||
        result_EXE !== 32'h0 || stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL reset: start=%b abort=%b stall=%b ready=%b result=%h stall_cycles=%0d, expected all 0",
               unit_start, unit_abort, stall_req, md_ready_EXE, result_EXE, stall_cycles);
    end
    md_valid_EXE = 1'b0;
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_mul();
    run_op(1'b0, 32'h0000_0015, 0);
    idle_cycle();
  endtask

  task automatic test_div();
    run_op(1'b1, 32'hFFFF_FFFF, 0);
    idle_cycle();
  endtask

  task automatic test_flush_busy();
    next_cycle();
    md_valid_EXE = 1'b1; md_is_div_EXE = 1'b0;
    next_cycle();
    next_cycle();
    flush_EXE = 1'b1;
    sample();
    checks++;
    if (unit_abort !== 1'b1 || stall_req !== 1'b0 || unit_start !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: abort=%b stall=%b start=%b, expected 1 0 0", unit_abort, stall_req, unit_start);
    end
    exp_stall = exp_stall + 32'd2;
    idle_cycle();
    checks++;
    if (result_EXE !== last_result || stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL flush_busy_after: result=%h stall_cycles=%0d, expected %h %0d",
               result_EXE, stall_cycles, last_result, exp_stall);
    end
  endtask

  task automatic test_flush_issue();
    next_cycle();
    md_valid_EXE = 1'b1; md_is_div_EXE = 1'b1; flush_EXE = 1'b1;
    sample();
    checks++;
    if (unit_start !== 1'b0 || unit_is_div !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_issue: start=%b is_div=%b stall=%b, expected 0 0 0", unit_start, unit_is_div, stall_req);
    end
    idle_cycle();
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL flush_issue_stall: got %0d expected %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_flush_capture();
    next_cycle();
    md_valid_EXE = 1'b1; md_is_div_EXE = 1'b0; flush_EXE = 1'b0;
    repeat (MUL_LAT) next_cycle();
    flush_EXE = 1'b1;
    unit_result = 32'hBAD0_BAD0;
    sample();
    checks++;
    if (unit_abort !== 1'b1 || unit_start !== 1'b0) begin
      errors++;
      $display("FAIL flush_capture: abort=%b start=%b, expected 1 0", unit_abort, unit_start);
    end
    exp_stall = exp_stall + 32'(MUL_LAT);
    idle_cycle();
    checks++;
    if (result_EXE !== last_result || stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL flush_capture_after: result=%h stall_cycles=%0d, expected %h %0d",
               result_EXE, stall_cycles, last_result, exp_stall);
    end
  endtask

  task automatic test_hold();
    run_op(1'b0, 32'h1234_5678, 3);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 32'h0000_1111, 0);
    run_op(1'b0, 32'h0000_2222, 0);
    idle_cycle();
  endtask

  task automatic test_reset_busy();
    next_cycle();
    md_valid_EXE = 1'b1; md_is_div_EXE = 1'b0;
    next_cycle();
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (unit_start !== 1'b0 || unit_abort !== 1'b0 || stall_req !== 1'b0 || md_ready_EXE !== 1'b0 ||
        result_EXE !== 32'h0 || stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy: start=%b abort=%b stall=%b ready=%b result=%h stall_cycles=%0d, expected all 0",
               unit_start, unit_abort, stall_req, md_ready_EXE, result_EXE, stall_cycles);
    end
    sample();
    md_valid_EXE = 1'b0;
    rst_n = 1'b1;
    exp_stall = 32'd0;
    last_result = 32'd0;
    idle_cycle();
    checks++;
    if (stall_cycles !== 32'd0 || result_EXE !== 32'd0) begin
      errors++;
      $display("FAIL reset_busy_after: stall_cycles=%0d result=%h, expected 0 0", stall_cycles, result_EXE);
    end
    run_op(1'b0, 32'h0000_00AB, 0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush_busy();
    test_flush_issue();
    test_flush_capture();
    test_hold();
    test_back_to_back();
    test_reset_busy();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
